// File: rtl/jtag_pkg.sv
// Shared types and constants for the s9234 JTAG TAP controller.
// TAP state encodings follow the classic 1149.1 4-bit assignment.
package jtag_pkg;

    typedef enum logic [3:0] {
        S_EX2_DR = 4'h0,
        S_EX1_DR = 4'h1,
        S_SH_DR  = 4'h2,
        S_PAU_DR = 4'h3,
        S_SEL_IR = 4'h4,
        S_UPD_DR = 4'h5,
        S_CAP_DR = 4'h6,
        S_SEL_DR = 4'h7,
        S_EX2_IR = 4'h8,
        S_EX1_IR = 4'h9,
        S_SH_IR  = 4'hA,
        S_PAU_IR = 4'hB,
        S_RTI    = 4'hC,
        S_UPD_IR = 4'hD,
        S_CAP_IR = 4'hE,
        S_TLR    = 4'hF
    } tap_state_t;

    localparam logic [1:0] INST_EXTEST  = 2'b00;
    localparam logic [1:0] INST_INTSCAN = 2'b01;
    localparam logic [1:0] INST_SAMPLE  = 2'b10;
    localparam logic [1:0] INST_BYPASS  = 2'b11;

    localparam logic [1:0] INST_RESET = INST_BYPASS;
    localparam logic [1:0] IR_CAPTURE = 2'b01;

    // EXTEST and INTSCAN both isolate the core.
    function automatic logic inst_isolates(input logic [1:0] i_inst);
        return (i_inst == INST_EXTEST) || (i_inst == INST_INTSCAN);
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP sequencer: owns the state register and TMS decode.
// i_en holds the state while reset release is still being synchronised.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_tms,
    output tap_state_t o_state,
    output tap_state_t o_next
);

    tap_state_t r_state;
    tap_state_t w_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_TLR;
        end else if (i_en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_TLR:    w_next = i_tms ? S_TLR    : S_RTI;
            S_RTI:    w_next = i_tms ? S_SEL_DR : S_RTI;
            S_SEL_DR: w_next = i_tms ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_next = i_tms ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_next = i_tms ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_next = i_tms ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: w_next = i_tms ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: w_next = i_tms ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_next = i_tms ? S_SEL_DR : S_RTI;
            S_SEL_IR: w_next = i_tms ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_next = i_tms ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_next = i_tms ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_next = i_tms ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: w_next = i_tms ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: w_next = i_tms ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_next = i_tms ? S_SEL_DR : S_RTI;
            default:  w_next = S_TLR;
        endcase
    end

    assign o_state = r_state;
    assign o_next  = w_next;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller for the s9234 scan wrapper: IR, bypass, chain decode
// and the falling-edge TDO mux feeding the chip TDO pin.
module jtag_tap_ctrl
    import jtag_pkg::*;
(
    input  logic       TCLK,
    input  logic       TRST,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       TDO_BSR,
    input  logic       TDO_ISR,
    output logic       TDO,
    output logic       tdo_en,
    output logic [1:0] inst,
    output logic       clockdr_bs,
    output logic       shiftdr_bs,
    output logic       updatedr_bs,
    output logic       clockdr_is,
    output logic       shiftdr_is,
    output logic       updatedr_is,
    output logic       test_mode,
    output logic [3:0] tap_state
);

    logic [1:0] r_sync;
    logic       w_run;
    logic       w_tdo_run;
    tap_state_t w_state;
    tap_state_t w_next;

    logic [1:0] r_ir_sr;
    logic [1:0] r_inst;
    logic       r_byp;
    logic       r_tdo;
    logic       r_tdo_en;

    logic       w_sel_bs;
    logic       w_sel_is;
    logic       w_cap_dr;
    logic       w_sh_dr;
    logic       w_upd_dr;
    logic       w_sh_ir;
    logic       w_tdo_src;
    logic       w_shifting;

    // Release of TRST is retimed; state only advances once stage 0 is set.
    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign w_run     = r_sync[0];
    assign w_tdo_run = r_sync[1];

    jtag_tap_fsm u_fsm (
        .i_clk   (TCLK),
        .i_rst_n (TRST),
        .i_en    (w_run),
        .i_tms   (TMS),
        .o_state (w_state),
        .o_next  (w_next)
    );

    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            r_ir_sr <= IR_CAPTURE;
            r_inst  <= INST_RESET;
            r_byp   <= 1'b0;
        end else if (w_run) begin
            if (w_next == S_TLR) begin
                r_ir_sr <= IR_CAPTURE;
                r_inst  <= INST_RESET;
                r_byp   <= 1'b0;
            end else begin
                case (w_state)
                    S_CAP_IR: r_ir_sr <= IR_CAPTURE;
                    S_SH_IR:  r_ir_sr <= {TDI, r_ir_sr[1]};
                    S_UPD_IR: r_inst  <= r_ir_sr;
                    S_CAP_DR: r_byp   <= 1'b0;
                    S_SH_DR:  r_byp   <= TDI;
                    default:  ;
                endcase
            end
        end
    end

    assign w_sel_bs = (r_inst == INST_EXTEST) || (r_inst == INST_SAMPLE);
    assign w_sel_is = (r_inst == INST_INTSCAN);

    assign w_cap_dr = (w_state == S_CAP_DR);
    assign w_sh_dr  = (w_state == S_SH_DR);
    assign w_upd_dr = (w_state == S_UPD_DR);
    assign w_sh_ir  = (w_state == S_SH_IR);

    assign clockdr_bs  = w_sel_bs & (w_cap_dr | w_sh_dr);
    assign shiftdr_bs  = w_sel_bs & w_sh_dr;
    assign updatedr_bs = w_sel_bs & w_upd_dr;
    assign clockdr_is  = w_sel_is & (w_cap_dr | w_sh_dr);
    assign shiftdr_is  = w_sel_is & w_sh_dr;
    assign updatedr_is = w_sel_is & w_upd_dr;

    assign test_mode = inst_isolates(r_inst) & (w_state != S_TLR);

    always_comb begin
        w_tdo_src  = r_tdo;
        w_shifting = 1'b0;
        if (w_sh_ir) begin
            w_tdo_src  = r_ir_sr[0];
            w_shifting = 1'b1;
        end else if (w_sh_dr) begin
            w_shifting = 1'b1;
            if (w_sel_bs) begin
                w_tdo_src = TDO_BSR;
            end else if (w_sel_is) begin
                w_tdo_src = TDO_ISR;
            end else begin
                w_tdo_src = r_byp;
            end
        end
    end

    // TDO changes on the falling edge so the far end samples it on the rise.
    always_ff @(negedge TCLK or negedge TRST) begin
        if (!TRST) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else if (w_tdo_run) begin
            if (w_state == S_TLR) begin
                r_tdo    <= 1'b0;
                r_tdo_en <= 1'b0;
            end else begin
                r_tdo    <= w_tdo_src;
                r_tdo_en <= w_shifting;
            end
        end
    end

    assign TDO       = r_tdo;
    assign tdo_en    = r_tdo_en;
    assign inst      = r_inst;
    assign tap_state = w_state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: reset, IR load, BSR/ISR/bypass
// scans, asynchronous TRST and the full TAP transition graph.
module tb_jtag_tap_ctrl;

    logic       TCLK = 1'b0;
    logic       TRST = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       TDO_BSR = 1'b0;
    logic       TDO_ISR = 1'b0;
    logic       TDO;
    logic       tdo_en;
    logic [1:0] inst;
    logic       clockdr_bs, shiftdr_bs, updatedr_bs;
    logic       clockdr_is, shiftdr_is, updatedr_is;
    logic       test_mode;
    logic [3:0] tap_state;

    logic [5:0] ctl;

    int n_tests = 0;
    int n_fail = 0;

    // state, next on TMS=0, next on TMS=1, path length and path from TLR
    logic [3:0] st_tab [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                                4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
    logic [3:0] n0_tab [16] = '{4'hC, 4'hC, 4'h6, 4'h2, 4'h2, 4'h3, 4'h3, 4'h2,
                                4'hC, 4'hE, 4'hA, 4'hA, 4'hB, 4'hB, 4'hA, 4'hC};
    logic [3:0] n1_tab [16] = '{4'hF, 4'h7, 4'h4, 4'h1, 4'h1, 4'h5, 4'h0, 4'h5,
                                4'h7, 4'hF, 4'h9, 4'h9, 4'hD, 4'h8, 4'hD, 4'h7};
    int         len_tab [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    logic [7:0] path_tab [16] = '{8'b0, 8'b0, 8'b10, 8'b010, 8'b0010, 8'b1010,
                                  8'b01010, 8'b101010, 8'b11010, 8'b110,
                                  8'b0110, 8'b00110, 8'b10110, 8'b010110,
                                  8'b1010110, 8'b110110};

    jtag_tap_ctrl dut (
        .TCLK        (TCLK),
        .TRST        (TRST),
        .TMS         (TMS),
        .TDI         (TDI),
        .TDO_BSR     (TDO_BSR),
        .TDO_ISR     (TDO_ISR),
        .TDO         (TDO),
        .tdo_en      (tdo_en),
        .inst        (inst),
        .clockdr_bs  (clockdr_bs),
        .shiftdr_bs  (shiftdr_bs),
        .updatedr_bs (updatedr_bs),
        .clockdr_is  (clockdr_is),
        .shiftdr_is  (shiftdr_is),
        .updatedr_is (updatedr_is),
        .test_mode   (test_mode),
        .tap_state   (tap_state)
    );

    assign ctl = {clockdr_bs, shiftdr_bs, updatedr_bs,
                  clockdr_is, shiftdr_is, updatedr_is};

    always #5 TCLK = ~TCLK;

    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCLK);
        #1;
    endtask

    task automatic goto_tlr();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    endtask

    task automatic load_ir(input logic [1:0] ins);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, ins[0]);
        step(1'b1, ins[1]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #1 TRST = 1'b0;
        #3;
        n_tests++;
        if (tap_state !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_state got %h want F", tap_state);
        end
        n_tests++;
        if (inst !== 2'b11 || test_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_inst got %b/%b want 11/0", inst, test_mode);
        end
        n_tests++;
        if (ctl !== 6'b0 || tdo_en !== 1'b0 || TDO !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out got ctl=%b en=%b tdo=%b want 0", ctl, tdo_en, TDO);
        end
        @(posedge TCLK);
        #1 TRST = 1'b1;
        step(1'b0, 1'b0);
        n_tests++;
        if (tap_state !== 4'hF) begin
            n_fail++;
            $display("FAIL release_hold got %h want F", tap_state);
        end
        step(1'b0, 1'b0);
        n_tests++;
        if (tap_state !== 4'hC) begin
            n_fail++;
            $display("FAIL release_rti got %h want C", tap_state);
        end
    endtask

    task automatic test_bypass();
        logic [3:0] din;
        logic [3:0] exp_tdo;
        din = 4'b1101;
        exp_tdo = 4'b1010;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_tests++;
        if (ctl !== 6'b0) begin
            n_fail++;
            $display("FAIL byp_cap_ctl got %b want 000000", ctl);
        end
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge TCLK);
            #1;
            n_tests++;
            if (TDO !== exp_tdo[i] || tdo_en !== 1'b1 || ctl !== 6'b0) begin
                n_fail++;
                $display("FAIL byp_tdo%0d got tdo=%b en=%b ctl=%b want %b/1/0",
                         i, TDO, tdo_en, ctl, exp_tdo[i]);
            end
            step(i == 3, din[i]);
        end
        step(1'b1, 1'b0);
        n_tests++;
        if (ctl !== 6'b0 || tap_state !== 4'h5) begin
            n_fail++;
            $display("FAIL byp_upd got ctl=%b st=%h want 0/5", ctl, tap_state);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_ir_extest();
        goto_tlr();
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        n_tests++;
        if (tap_state !== 4'hA) begin
            n_fail++;
            $display("FAIL ir_path got %h want A", tap_state);
        end
        @(negedge TCLK);
        #1;
        n_tests++;
        if (TDO !== 1'b1 || tdo_en !== 1'b1) begin
            n_fail++;
            $display("FAIL ir_tdo0 got %b/%b want 1/1", TDO, tdo_en);
        end
        step(1'b0, 1'b0);
        @(negedge TCLK);
        #1;
        n_tests++;
        if (TDO !== 1'b0 || tdo_en !== 1'b1) begin
            n_fail++;
            $display("FAIL ir_tdo1 got %b/%b want 0/1", TDO, tdo_en);
        end
        step(1'b1, 1'b0);
        @(negedge TCLK);
        #1;
        n_tests++;
        if (tdo_en !== 1'b0 || tap_state !== 4'h9) begin
            n_fail++;
            $display("FAIL ir_exit got en=%b st=%h want 0/9", tdo_en, tap_state);
        end
        step(1'b1, 1'b0);
        n_tests++;
        if (inst !== 2'b11 || tap_state !== 4'hD) begin
            n_fail++;
            $display("FAIL ir_upd got inst=%b st=%h want 11/D", inst, tap_state);
        end
        step(1'b0, 1'b0);
        n_tests++;
        if (inst !== 2'b00 || test_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL ir_effect got inst=%b tm=%b want 00/1", inst, test_mode);
        end
    endtask

    task automatic test_dr_scan(input logic [1:0] ins, input logic [5:0] cap_ctl,
                                input logic [5:0] sh_ctl, input logic [5:0] upd_ctl,
                                input logic exp_tm);
        logic [71:0] pat;
        logic        b;
        pat = {$urandom, $urandom, $urandom};
        n_tests++;
        if (inst !== ins || test_mode !== exp_tm) begin
            n_fail++;
            $display("FAIL dr_inst got %b/%b want %b/%b", inst, test_mode, ins, exp_tm);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_tests++;
        if (ctl !== cap_ctl) begin
            n_fail++;
            $display("FAIL dr_cap_ctl got %b want %b", ctl, cap_ctl);
        end
        step(1'b0, 1'b0);
        for (int i = 0; i < 72; i++) begin
            n_tests++;
            if (ctl !== sh_ctl) begin
                n_fail++;
                $display("FAIL dr_sh_ctl%0d got %b want %b", i, ctl, sh_ctl);
            end
            b = pat[i];
            TDO_BSR = ins[0] ? ~b : b;
            TDO_ISR = ins[0] ? b : ~b;
            @(negedge TCLK);
            #1;
            n_tests++;
            if (TDO !== b || tdo_en !== 1'b1) begin
                n_fail++;
                $display("FAIL dr_tdo%0d got %b/%b want %b/1", i, TDO, tdo_en, b);
            end
            step(i == 71, 1'b0);
        end
        n_tests++;
        if (ctl !== 6'b0 || tap_state !== 4'h1) begin
            n_fail++;
            $display("FAIL dr_ex1 got ctl=%b st=%h want 0/1", ctl, tap_state);
        end
        TDO_BSR = ~TDO_BSR;
        TDO_ISR = ~TDO_ISR;
        @(negedge TCLK);
        #1;
        n_tests++;
        if (TDO !== pat[71] || tdo_en !== 1'b0) begin
            n_fail++;
            $display("FAIL dr_hold got %b/%b want %b/0", TDO, tdo_en, pat[71]);
        end
        step(1'b1, 1'b0);
        n_tests++;
        if (ctl !== upd_ctl) begin
            n_fail++;
            $display("FAIL dr_upd_ctl got %b want %b", ctl, upd_ctl);
        end
        step(1'b0, 1'b0);
        n_tests++;
        if (ctl !== 6'b0 || tap_state !== 4'hC) begin
            n_fail++;
            $display("FAIL dr_rti got ctl=%b st=%h want 0/C", ctl, tap_state);
        end
    endtask

    task automatic test_trst_midshift();
        load_ir(2'b00);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        n_tests++;
        if (tap_state !== 4'h2 || test_mode !== 1'b1 || ctl !== 6'b110000) begin
            n_fail++;
            $display("FAIL trst_pre got st=%h tm=%b ctl=%b want 2/1/110000",
                     tap_state, test_mode, ctl);
        end
        #2 TRST = 1'b0;
        #1;
        n_tests++;
        if (tap_state !== 4'hF || inst !== 2'b11) begin
            n_fail++;
            $display("FAIL trst_state got st=%h inst=%b want F/11", tap_state, inst);
        end
        n_tests++;
        if (test_mode !== 1'b0 || ctl !== 6'b0) begin
            n_fail++;
            $display("FAIL trst_ctl got tm=%b ctl=%b want 0/0", test_mode, ctl);
        end
        @(posedge TCLK);
        #1 TRST = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        n_tests++;
        if (tap_state !== 4'hC) begin
            n_fail++;
            $display("FAIL trst_release got %h want C", tap_state);
        end
    endtask

    task automatic goto_state(input int k);
        goto_tlr();
        for (int i = 0; i < len_tab[k]; i++) step(path_tab[k][i], 1'b0);
    endtask

    task automatic test_transitions();
        for (int k = 0; k < 16; k++) begin
            goto_state(k);
            n_tests++;
            if (tap_state !== st_tab[k]) begin
                n_fail++;
                $display("FAIL path_%h got %h", st_tab[k], tap_state);
            end
            step(1'b0, 1'b0);
            n_tests++;
            if (tap_state !== n0_tab[k]) begin
                n_fail++;
                $display("FAIL tms0_%h got %h want %h", st_tab[k], tap_state, n0_tab[k]);
            end
            goto_state(k);
            step(1'b1, 1'b0);
            n_tests++;
            if (tap_state !== n1_tab[k]) begin
                n_fail++;
                $display("FAIL tms1_%h got %h want %h", st_tab[k], tap_state, n1_tab[k]);
            end
            goto_state(k);
            goto_tlr();
            n_tests++;
            if (tap_state !== 4'hF || inst !== 2'b11 || test_mode !== 1'b0) begin
                n_fail++;
                $display("FAIL tlr5_%h got st=%h inst=%b tm=%b want F/11/0",
                         st_tab[k], tap_state, inst, test_mode);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_ir_extest();
        test_dr_scan(2'b00, 6'b100000, 6'b110000, 6'b001000, 1'b1);
        load_ir(2'b01);
        test_dr_scan(2'b01, 6'b000100, 6'b000110, 6'b000001, 1'b1);
        load_ir(2'b10);
        test_dr_scan(2'b10, 6'b100000, 6'b110000, 6'b001000, 1'b0);
        test_trst_midshift();
        test_transitions();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
